// File: rtl/alarm_if.sv
// Alarm controller port bundle: keypad/sensor inputs and siren/status outputs.
interface alarm_if #(
  parameter int N_SENSORS = 3
);
  logic                 arm;
  logic                 disarm;
  logic [N_SENSORS-1:0] sensors;
  logic [N_SENSORS-1:0] delayed_mask;
  logic                 armed;
  logic                 entry;
  logic                 siren;
  logic [N_SENSORS-1:0] zone_latch;
  logic [2:0]           state;

  modport master (
    output arm, disarm, sensors, delayed_mask,
    input  armed, entry, siren, zone_latch, state
  );

  modport slave (
    input  arm, disarm, sensors, delayed_mask,
    output armed, entry, siren, zone_latch, state
  );
endinterface

// File: rtl/alarm_controller.sv
// Multi-zone alarm: arm/disarm FSM, instant and entry-delayed zones, latched trips,
// retriggerable time-limited siren. Optional macro ALARM_SENSOR_SYNC_EN adds a 2-flop sensor synchroniser.
module alarm_controller #(
  parameter int N_SENSORS   = 3,
  parameter int ENTRY_DELAY = 16,
  parameter int SIREN_TIME  = 64
) (
  input logic    clk,
  input logic    reset,
  alarm_if.slave bus
);
  localparam int MAX_T = (ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME;
  localparam int CNT_W = $clog2(MAX_T) + 1;
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMED    = 3'd1,
    S_ENTRY    = 3'd2,
    S_ALARM    = 3'd3,
    S_SILENCED = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  logic [N_SENSORS-1:0] sens_s;
  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 armed_q, entry_q, siren_q;
  logic [N_SENSORS-1:0] zone_q;
  logic                 inst, dly, any_s;

`ifdef ALARM_SENSOR_SYNC_EN
  logic [N_SENSORS-1:0] sens_p0, sens_p1;

  // Stage p0/p1: two-flop synchroniser ahead of all sensor logic
  always_ff @(posedge clk) begin
    if (reset) begin
      sens_p0 <= '0;
      sens_p1 <= '0;
    end else begin
      sens_p0 <= bus.sensors;
      sens_p1 <= sens_p0;
    end
  end
  assign sens_s = sens_p1;
`else
  assign sens_s = bus.sensors;
`endif

  assign inst  = |(sens_s & ~bus.delayed_mask);
  assign dly   = |(sens_s & bus.delayed_mask);
  assign any_s = |sens_s;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      S_DISARMED: begin
        if (bus.arm && !bus.disarm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (inst) begin
          state_nxt = S_ALARM;
          cnt_nxt   = SIREN_LOAD;
        end else if (dly) begin
          state_nxt = S_ENTRY;
          cnt_nxt   = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        if (inst || cnt_q == '0) begin
          state_nxt = S_ALARM;
          cnt_nxt   = SIREN_LOAD;
        end else begin
          cnt_nxt = sat_dec(cnt_q);
        end
      end
      S_ALARM: begin
        // A fresh trip keeps the siren going a full period from now
        if (any_s) begin
          cnt_nxt = SIREN_LOAD;
        end else if (cnt_q == '0) begin
          state_nxt = S_SILENCED;
        end else begin
          cnt_nxt = sat_dec(cnt_q);
        end
      end
      S_SILENCED: begin
        if (any_s) begin
          state_nxt = S_ALARM;
          cnt_nxt   = SIREN_LOAD;
        end
      end
      default: begin
        state_nxt = S_DISARMED;
        cnt_nxt   = '0;
      end
    endcase
    if (bus.disarm && state_q != S_DISARMED) begin
      state_nxt = S_DISARMED;
      cnt_nxt   = '0;
    end
  end

  // Stage p2: state, counter and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DISARMED;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      entry_q <= 1'b0;
      siren_q <= 1'b0;
      zone_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      armed_q <= (state_nxt != S_DISARMED);
      entry_q <= (state_nxt == S_ENTRY);
      siren_q <= (state_nxt == S_ALARM);
      if (state_q == S_DISARMED) begin
        if (state_nxt == S_ARMED) zone_q <= '0;
      end else begin
        zone_q <= zone_q | sens_s;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.armed      = armed_q;
  assign bus.entry      = entry_q;
  assign bus.siren      = siren_q;
  assign bus.zone_latch = zone_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller (default build): vector table plus multi-cycle sequences.
module tb_alarm_controller;
  localparam int N  = 3;
  localparam int ED = 16;
  localparam int ST = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_if #(.N_SENSORS(N)) bus ();

  alarm_controller #(
    .N_SENSORS  (N),
    .ENTRY_DELAY(ED),
    .SIREN_TIME (ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       arm;
    logic       disarm;
    logic [2:0] sens;
    logic [2:0] dmask;
    logic [2:0] st;
    logic       armd;
    logic       ent;
    logic       sir;
    logic [2:0] zl;
  } vec_t;

  vec_t tbl[13];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic d, input logic [2:0] s, input logic [2:0] m);
    bus.arm          = a;
    bus.disarm       = d;
    bus.sensors      = s;
    bus.delayed_mask = m;
  endtask

  task automatic cycle(input logic a, input logic d, input logic [2:0] s);
    drive(a, d, s, 3'b001);
    step();
    drive(1'b0, 1'b0, 3'b000, 3'b001);
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic a,
                           input logic e, input logic s, input logic [2:0] zl);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".armed"}, 32'(bus.armed), 32'(a));
    check({tag, ".entry"}, 32'(bus.entry), 32'(e));
    check({tag, ".siren"}, 32'(bus.siren), 32'(s));
    check({tag, ".zone_latch"}, 32'(bus.zone_latch), 32'(zl));
  endtask

  initial begin
    int n, guard, seen;

    tbl[0]  = '{1'b0, 1'b0, 3'b000, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 1'b0, 3'b111, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[2]  = '{1'b1, 1'b1, 3'b000, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[3]  = '{1'b1, 1'b0, 3'b000, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[4]  = '{1'b1, 1'b0, 3'b000, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 3'b010, 3'b001, 3'd3, 1'b1, 1'b0, 1'b1, 3'b010};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b001, 3'd3, 1'b1, 1'b0, 1'b1, 3'b010};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 3'b010};
    tbl[8]  = '{1'b1, 1'b0, 3'b000, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[9]  = '{1'b0, 1'b0, 3'b001, 3'b001, 3'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    tbl[10] = '{1'b0, 1'b0, 3'b001, 3'b001, 3'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    tbl[11] = '{1'b0, 1'b0, 3'b100, 3'b001, 3'd3, 1'b1, 1'b0, 1'b1, 3'b101};
    tbl[12] = '{1'b0, 1'b1, 3'b000, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 3'b101};

    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 3'b001);
    step();
    step();
    check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].arm, tbl[i].disarm, tbl[i].sens, tbl[i].dmask);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].armd, tbl[i].ent, tbl[i].sir, tbl[i].zl);
    end
    drive(1'b0, 1'b0, 3'b000, 3'b001);

    // Instant zone: siren exactly SIREN_TIME cycles, then SILENCED
    cycle(1'b1, 1'b0, 3'b000);
    check("instA.armed_state", 32'(bus.state), 32'd1);
    cycle(1'b0, 1'b0, 3'b010);
    check("instA.siren_on", 32'(bus.siren), 32'd1);
    n = 1; guard = 0;
    while (bus.siren === 1'b1 && guard < 200) begin
      step(); guard++;
      if (bus.siren === 1'b1) n++;
    end
    check("instA.siren_len", 32'(n), 32'(ST));
    check_all("instA.end", 3'd4, 1'b1, 1'b0, 1'b0, 3'b010);

    // Delayed zone: entry exactly ENTRY_DELAY cycles, then siren
    cycle(1'b0, 1'b1, 3'b000);
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b001);
    check("dlyB.entry_on", 32'(bus.entry), 32'd1);
    n = 1; guard = 0;
    while (bus.entry === 1'b1 && guard < 200) begin
      step(); guard++;
      if (bus.entry === 1'b1) n++;
    end
    check("dlyB.entry_len", 32'(n), 32'(ED));
    check_all("dlyB.alarm", 3'd3, 1'b1, 1'b0, 1'b1, 3'b001);

    // Disarm at entry cycle 10: siren never asserts
    cycle(1'b0, 1'b1, 3'b000);
    check("dlyB2.disarmed", 32'(bus.state), 32'd0);
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b001);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.siren !== 1'b0) seen++;
    end
    check("dlyB2.entry_c10", 32'(bus.entry), 32'd1);
    cycle(1'b0, 1'b1, 3'b000);
    check_all("dlyB2.disarm", 3'd0, 1'b0, 1'b0, 1'b0, 3'b001);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.siren !== 1'b0) seen++;
    end
    check("dlyB2.siren_never", 32'(seen), 32'd0);

    // ENTRY with 5 cycles remaining, instant zone cuts it short
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b001);
    for (int i = 0; i < 11; i++) step();
    check("entC.still_entry", 32'(bus.entry), 32'd1);
    cycle(1'b0, 1'b0, 3'b100);
    check_all("entC.alarm", 3'd3, 1'b1, 1'b0, 1'b1, 3'b101);

    // SILENCED retrigger, then retrigger at alarm cycle 60
    guard = 0;
    while (bus.state !== 3'd4 && guard < 200) begin
      step(); guard++;
    end
    check("retD.silenced", 32'(bus.state), 32'd4);
    cycle(1'b0, 1'b0, 3'b001);
    check("retD.alarm", 32'(bus.state), 32'd3);
    seen = 0;
    for (int i = 0; i < 59; i++) begin
      step();
      if (bus.siren !== 1'b1) seen++;
    end
    check("retD.siren_held60", 32'(seen), 32'd0);
    cycle(1'b0, 1'b0, 3'b010);
    n = 1; guard = 0;
    while (bus.siren === 1'b1 && guard < 200) begin
      step(); guard++;
      if (bus.siren === 1'b1) n++;
    end
    check("retD.siren_len", 32'(n), 32'(ST));
    check_all("retD.end", 3'd4, 1'b1, 1'b0, 1'b0, 3'b111);

    // Reset during ALARM; arm+disarm together stays DISARMED
    cycle(1'b0, 1'b0, 3'b100);
    check("rstE.alarm", 32'(bus.siren), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("rstE.reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    cycle(1'b1, 1'b1, 3'b000);
    check_all("rstE.arm_disarm", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
